// File: rtl/alu_arbiter_if.sv
// Bundle of request, shared-ALU and response signals between two requesters
// and the alu_arbiter. The arbiter connects through the slave modport; the
// requesters and ALU sit on the master side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);

  logic             req_valid_0;
  logic             req_valid_1;
  logic             req_ready_0;
  logic             req_ready_1;
  logic [3:0]       req_sel_0;
  logic [3:0]       req_sel_1;
  logic [WIDTH-1:0] req_a_0;
  logic [WIDTH-1:0] req_b_0;
  logic [WIDTH-1:0] req_a_1;
  logic [WIDTH-1:0] req_b_1;

  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             rsp_valid_0;
  logic             rsp_valid_1;
  logic             rsp_ready_0;
  logic             rsp_ready_1;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;

  logic [15:0]      issue_cnt_0;
  logic [15:0]      issue_cnt_1;

  modport slave (
    input  req_valid_0, req_valid_1, req_sel_0, req_sel_1,
           req_a_0, req_b_0, req_a_1, req_b_1,
           alu_result, alu_zero, rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1, alu_sel, alu_a, alu_b,
           rsp_valid_0, rsp_valid_1, rsp_data, rsp_zero,
           issue_cnt_0, issue_cnt_1
  );

  modport master (
    output req_valid_0, req_valid_1, req_sel_0, req_sel_1,
           req_a_0, req_b_0, req_a_1, req_b_1,
           alu_result, alu_zero, rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1, alu_sel, alu_a, alu_b,
           rsp_valid_0, rsp_valid_1, rsp_data, rsp_zero,
           issue_cnt_0, issue_cnt_1
  );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation is in flight at a time: accept (IDLE), capture the ALU result
// (EXEC), then hold the registered result until the owner consumes it (RESP).
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [15:0]      issue_cnt_0_q, issue_cnt_0_d;
  logic [15:0]      issue_cnt_1_q, issue_cnt_1_d;

  logic             grant_0;
  logic             grant_1;
  logic             req_ready_0;
  logic             req_ready_1;
  logic             rsp_valid_0;
  logic             rsp_valid_1;

  // Round-robin pick: a lone requester always wins, a tie goes to whoever was not served last
  always_comb begin
    grant_0 = bus.req_valid_0 && (!bus.req_valid_1 || last_grant_q);
    grant_1 = bus.req_valid_1 && (!bus.req_valid_0 || !last_grant_q);
  end

  // Next-state, latch updates and handshake outputs for the IDLE/EXEC/RESP sequence
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    sel_d         = sel_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;
    issue_cnt_0_d = issue_cnt_0_q;
    issue_cnt_1_d = issue_cnt_1_q;
    req_ready_0   = 1'b0;
    req_ready_1   = 1'b0;
    rsp_valid_0   = 1'b0;
    rsp_valid_1   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_0 = grant_0 && rst_n;
        req_ready_1 = grant_1 && rst_n;
        if (grant_0) begin
          sel_d         = bus.req_sel_0;
          a_d           = bus.req_a_0;
          b_d           = bus.req_b_0;
          owner_d       = 1'b0;
          last_grant_d  = 1'b0;
          issue_cnt_0_d = issue_cnt_0_q + 16'd1;
          state_d       = EXEC;
        end else if (grant_1) begin
          sel_d         = bus.req_sel_1;
          a_d           = bus.req_a_1;
          b_d           = bus.req_b_1;
          owner_d       = 1'b1;
          last_grant_d  = 1'b1;
          issue_cnt_1_d = issue_cnt_1_q + 16'd1;
          state_d       = EXEC;
        end
      end

      EXEC: begin
        rsp_data_d = bus.alu_result;
        rsp_zero_d = bus.alu_zero;
        state_d    = RESP;
      end

      RESP: begin
        rsp_valid_0 = !owner_q && rst_n;
        rsp_valid_1 = owner_q && rst_n;
        if (owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation and gives requester 0 the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      sel_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
      issue_cnt_0_q <= '0;
      issue_cnt_1_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      sel_q         <= sel_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
      issue_cnt_0_q <= issue_cnt_0_d;
      issue_cnt_1_q <= issue_cnt_1_d;
    end
  end

  assign bus.req_ready_0 = req_ready_0;
  assign bus.req_ready_1 = req_ready_1;
  assign bus.alu_sel     = sel_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.rsp_valid_0 = rsp_valid_0;
  assign bus.rsp_valid_1 = rsp_valid_1;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.issue_cnt_0 = issue_cnt_0_q;
  assign bus.issue_cnt_1 = issue_cnt_1_q;

endmodule
